// File: rtl/pl_pkg.sv
// Shared types and constants for the pipeline hazard unit.
// Slot records carry destination info down EX, MEM and WB.
package pl_pkg;

  localparam int AW_MAX = 8;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef logic [AW_MAX-1:0] reg_t;

  typedef struct packed {
    logic valid;
    reg_t rd;
    logic reg_write;
    logic mem_read;
  } slot_t;

  typedef struct packed {
    reg_t rs1;
    reg_t rs2;
    logic use_rs1;
    logic use_rs2;
  } ex_src_t;

  function automatic logic is_src(slot_t s);
    return s.valid & s.reg_write & (s.rd != '0);
  endfunction

  function automatic logic hit(slot_t s, reg_t r, logic u);
    return u & is_src(s) & (s.rd == r);
  endfunction

endpackage

// File: rtl/pl_hazard_unit_if.sv
// ID-stage instruction info in, pipeline control out.
// master drives the ID view; slave is the hazard unit.
interface pl_hazard_unit_if #(
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              mem_branch_taken;

  logic              pc_write;
  logic              if_id_write;
  logic              id_ex_bubble;
  logic              flush_if_id;
  logic              flush_id_ex;
  logic              flush_ex_mem;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;

  modport master (
    output id_valid, id_rs1, id_rs2,
    output id_use_rs1, id_use_rs2,
    output id_rd, id_reg_write, id_mem_read,
    output mem_branch_taken,
    input  pc_write, if_id_write,
    input  id_ex_bubble,
    input  flush_if_id, flush_id_ex,
    input  flush_ex_mem,
    input  fwd_a, fwd_b
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2,
    input  id_use_rs1, id_use_rs2,
    input  id_rd, id_reg_write, id_mem_read,
    input  mem_branch_taken,
    output pc_write, if_id_write,
    output id_ex_bubble,
    output flush_if_id, flush_id_ex,
    output flush_ex_mem,
    output fwd_a, fwd_b
  );
endinterface

// File: rtl/pl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module pl_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pl_hazard_unit.sv
// Stall/flush/forward control for a 5-stage pipeline whose
// branches resolve in MEM; tracks EX, MEM and WB shadows.
module pl_hazard_unit
  import pl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32,
  parameter int FWD_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  pl_hazard_unit_if.slave  bus,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  slot_t   ex_q, mem_q, wb_q;
  ex_src_t exs_q;

  reg_t id_rs1, id_rs2, id_rd;
  logic hit_ex, hit_mem, hit_wb;
  logic stall_raw, stall, flush;
  logic [1:0] fa, fb;
  logic unused_mr;

  assign id_rs1 = reg_t'(bus.id_rs1);
  assign id_rs2 = reg_t'(bus.id_rs2);
  assign id_rd  = reg_t'(bus.id_rd);

  assign hit_ex  = hit(ex_q, id_rs1, bus.id_use_rs1)
                 | hit(ex_q, id_rs2, bus.id_use_rs2);
  assign hit_mem = hit(mem_q, id_rs1, bus.id_use_rs1)
                 | hit(mem_q, id_rs2, bus.id_use_rs2);
  assign hit_wb  = hit(wb_q, id_rs1, bus.id_use_rs1)
                 | hit(wb_q, id_rs2, bus.id_use_rs2);

  // Without forwarding, any older in-flight writer blocks ID.
  assign stall_raw = bus.id_valid & ((FWD_EN != 0)
                   ? (hit_ex & ex_q.mem_read)
                   : (hit_ex | hit_mem | hit_wb));

  assign flush = bus.mem_branch_taken & ~rst;
  assign stall = stall_raw & ~flush;

  assign bus.pc_write     = ~stall;
  assign bus.if_id_write  = ~stall;
  assign bus.id_ex_bubble = stall | flush;
  assign bus.flush_if_id  = flush;
  assign bus.flush_id_ex  = flush;
  assign bus.flush_ex_mem = flush;

  always_comb begin
    fa = FWD_RF;
    fb = FWD_RF;
    if (FWD_EN != 0) begin
      if (hit(mem_q, exs_q.rs1, exs_q.use_rs1))
        fa = FWD_MEM;
      else if (hit(wb_q, exs_q.rs1, exs_q.use_rs1))
        fa = FWD_WB;
      if (hit(mem_q, exs_q.rs2, exs_q.use_rs2))
        fb = FWD_MEM;
      else if (hit(wb_q, exs_q.rs2, exs_q.use_rs2))
        fb = FWD_WB;
    end
  end

  assign bus.fwd_a = fa;
  assign bus.fwd_b = fb;

  assign unused_mr = mem_q.mem_read ^ wb_q.mem_read;

  // On a flush the branch in MEM still retires into WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      exs_q <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= flush ? '0 : ex_q;
      if (stall || flush || !bus.id_valid) begin
        ex_q  <= '0;
        exs_q <= '0;
      end else begin
        ex_q <= '{valid:     1'b1,
                  rd:        id_rd,
                  reg_write: bus.id_reg_write,
                  mem_read:  bus.id_mem_read};
        exs_q <= '{rs1:     id_rs1,
                   rs2:     id_rs2,
                   use_rs1: bus.id_use_rs1,
                   use_rs2: bus.id_use_rs2};
      end
    end
  end

  pl_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall),
    .count (stall_cnt)
  );

  pl_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pl_hazard_unit.sv
// Directed bench: forwarding unit stepped through a vector table,
// plus a no-forwarding unit (2-bit counters) and reset corners.
module tb_pl_hazard_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pl_hazard_unit_if #(.REG_AW(5)) if0 ();
  pl_hazard_unit_if #(.REG_AW(5)) if1 ();

  logic [31:0] sc0, fc0;
  logic [1:0]  sc1, fc1;

  pl_hazard_unit #(.REG_AW(5), .CNT_W(32), .FWD_EN(1)) u0 (
    .clk       (clk),
    .rst       (rst),
    .bus       (if0.slave),
    .stall_cnt (sc0),
    .flush_cnt (fc0)
  );

  pl_hazard_unit #(.REG_AW(5), .CNT_W(2), .FWD_EN(0)) u1 (
    .clk       (clk),
    .rst       (rst),
    .bus       (if1.slave),
    .stall_cnt (sc1),
    .flush_cnt (fc1)
  );

  typedef struct {
    logic       v;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       rw, mr, br;
    logic [5:0] ctl;
    logic [1:0] fa, fb;
    int         sc, fc;
  } vec_t;

  // ctl = {pc_write, if_id_write, bubble, flush_if_id, flush_id_ex, flush_ex_mem}
  localparam logic [5:0] N = 6'b110000;
  localparam logic [5:0] S = 6'b001000;
  localparam logic [5:0] F = 6'b111111;

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic v, int rs1, int rs2, logic u1, logic u2,
                              int rd, logic rw, logic mr, logic br,
                              logic [5:0] ctl, logic [1:0] fa, logic [1:0] fb,
                              int sc, int fc);
    vec_t t;
    t.v = v; t.rs1 = 5'(rs1); t.rs2 = 5'(rs2);
    t.u1 = u1; t.u2 = u2; t.rd = 5'(rd);
    t.rw = rw; t.mr = mr; t.br = br;
    t.ctl = ctl; t.fa = fa; t.fb = fb;
    t.sc = sc; t.fc = fc;
    return t;
  endfunction

  task automatic set0(logic v, int rs1, int rs2, logic u1, logic u2,
                      int rd, logic rw, logic mr, logic br);
    if0.id_valid = v;
    if0.id_rs1 = 5'(rs1); if0.id_rs2 = 5'(rs2);
    if0.id_use_rs1 = u1; if0.id_use_rs2 = u2;
    if0.id_rd = 5'(rd);
    if0.id_reg_write = rw; if0.id_mem_read = mr;
    if0.mem_branch_taken = br;
  endtask

  task automatic set1(logic v, int rs1, int rs2, logic u1, logic u2,
                      int rd, logic rw);
    if1.id_valid = v;
    if1.id_rs1 = 5'(rs1); if1.id_rs2 = 5'(rs2);
    if1.id_use_rs1 = u1; if1.id_use_rs2 = u2;
    if1.id_rd = 5'(rd);
    if1.id_reg_write = rw; if1.id_mem_read = 1'b0;
    if1.mem_branch_taken = 1'b0;
  endtask

  function automatic logic [5:0] ctl0();
    return {if0.pc_write, if0.if_id_write, if0.id_ex_bubble,
            if0.flush_if_id, if0.flush_id_ex, if0.flush_ex_mem};
  endfunction

  function automatic logic [5:0] ctl1();
    return {if1.pc_write, if1.if_id_write, if1.id_ex_bubble,
            if1.flush_if_id, if1.flush_id_ex, if1.flush_ex_mem};
  endfunction

  // add x5 then or x8,x5,x0 on the no-forwarding unit; returns stall cycles
  task automatic run_raw(output int n, output logic fwd_bad);
    n = 0;
    fwd_bad = 1'b0;
    set1(1, 1, 0, 1, 0, 5, 1);
    @(posedge clk); #1;
    set1(1, 5, 0, 1, 1, 8, 1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (if1.fwd_a !== 2'b00 || if1.fwd_b !== 2'b00) fwd_bad = 1'b1;
      if (if1.pc_write !== 1'b0) break;
      n++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    set1(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  vec_t tbl [14];
  int   nst;
  logic fbad;

  initial begin
    tbl[0]  = mk(1, 2, 0, 1, 0, 5, 1, 1, 0, N, 2'b00, 2'b00, 0, 0);
    tbl[1]  = mk(1, 5, 1, 1, 1, 6, 1, 0, 0, S, 2'b00, 2'b00, 0, 0);
    tbl[2]  = mk(1, 5, 1, 1, 1, 6, 1, 0, 0, N, 2'b00, 2'b00, 1, 0);
    tbl[3]  = mk(1, 6, 6, 1, 1, 7, 1, 0, 0, N, 2'b01, 2'b00, 1, 0);
    tbl[4]  = mk(1, 7, 6, 1, 1, 8, 1, 0, 0, N, 2'b10, 2'b10, 1, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, N, 2'b10, 2'b01, 1, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, N, 2'b00, 2'b00, 1, 0);
    tbl[7]  = mk(1, 0, 0, 0, 0, 0, 1, 1, 0, N, 2'b00, 2'b00, 1, 0);
    tbl[8]  = mk(1, 0, 0, 1, 1, 9, 1, 0, 0, N, 2'b00, 2'b00, 1, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, N, 2'b00, 2'b00, 1, 0);
    tbl[10] = mk(1, 0, 0, 0, 0, 11, 1, 1, 0, N, 2'b00, 2'b00, 1, 0);
    tbl[11] = mk(1, 11, 0, 1, 0, 12, 1, 0, 1, F, 2'b00, 2'b00, 1, 0);
    tbl[12] = mk(1, 12, 0, 1, 0, 13, 1, 0, 0, N, 2'b00, 2'b00, 1, 1);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, N, 2'b00, 2'b00, 1, 1);

    set0(1, 5, 5, 1, 1, 5, 1, 1, 1);
    set1(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctl", 64'(ctl0()), 64'(N));
    chk("reset_fwd", 64'({if0.fwd_a, if0.fwd_b}), 64'(0));
    chk("reset_cnt", 64'({sc0, fc0}), 64'(0));

    @(posedge clk); #1;
    rst = 1'b0;
    set0(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      set0(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2,
           tbl[i].rd, tbl[i].rw, tbl[i].mr, tbl[i].br);
      @(negedge clk);
      chk($sformatf("v%0d_ctl", i), 64'(ctl0()), 64'(tbl[i].ctl));
      chk($sformatf("v%0d_fwd", i), 64'({if0.fwd_a, if0.fwd_b}),
          64'({tbl[i].fa, tbl[i].fb}));
      chk($sformatf("v%0d_cnt", i), {sc0, fc0},
          {32'(tbl[i].sc), 32'(tbl[i].fc)});
      @(posedge clk); #1;
    end
    set0(0, 0, 0, 0, 0, 0, 0, 0, 0);

    run_raw(nst, fbad);
    chk("raw_stalls", 64'(nst), 64'(3));
    chk("raw_fwd_zero", 64'(fbad), 64'(0));
    chk("raw_stall_cnt", 64'(sc1), 64'(3));
    chk("raw_ctl_after", 64'(ctl1()), 64'(N));

    run_raw(nst, fbad);
    chk("raw2_stalls", 64'(nst), 64'(3));
    chk("sat_stall_cnt", 64'(sc1), 64'(3));

    set0(1, 0, 0, 0, 0, 5, 1, 1, 0);
    @(posedge clk); #1;
    set0(1, 5, 0, 1, 0, 6, 1, 0, 0);
    @(negedge clk);
    chk("pre_rst_stall", 64'(ctl0()), 64'(S));
    rst = 1'b1;
    #1;
    chk("rst_mid_ctl", 64'(ctl0()), 64'(N));
    chk("rst_mid_cnt0", 64'({sc0, fc0}), 64'(0));
    chk("rst_mid_cnt1", 64'({sc1, fc1}), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ctl", 64'(ctl0()), 64'(N));
    @(posedge clk); #1;
    set0(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("post_rst_cnt", 64'({sc0, fc0}), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
